// File: rtl/mips_pkg.sv
// mips_pkg: fetch FSM encoding and instruction-word constants shared by the fetch path.
package mips_pkg;
  typedef enum logic [1:0] {FS_BOOT = 2'd0, FS_RUN = 2'd1, FS_HALT = 2'd2} fetch_state_e;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;
endpackage

// File: rtl/fetch_q.sv
// fetch_q: 2-entry FIFO holding {pc, instr} pairs; flush wins over push.
module fetch_q
  import mips_pkg::*;
#(
  parameter int W = INSTR_W + 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic         rd_q, wr_q;
  logic [1:0]   cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch PC sequencer feeding a 2-entry queue to decode, with
// redirect/exception vectoring and halt.
module ifetch_ctrl
  import mips_pkg::*;
#(
  parameter int                  PC_WIDTH   = 6,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR = 'h3C
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  input  logic                halt_req,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                exc_valid,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                misalign,
  output logic                halted
);
  fetch_state_e                   state_q, state_d;
  logic [PC_WIDTH-1:0]            fpc_q, fpc_d;
  logic                           mis_q, mis_d;
  logic [1:0]                     count;
  logic                           pop, push, flush, space;
  logic [PC_WIDTH+INSTR_W-1:0]    head;
  assign pop   = out_valid & out_ready;
  assign flush = redirect_valid | exc_valid;
  // a full queue still has room when its head leaves this cycle
  assign space = ~count[1] | pop;
  assign push  = (state_q == FS_RUN) & space & ~flush;
  always_comb begin
    state_d = (state_q == FS_BOOT && fetch_en)  ? FS_RUN  :
              (state_q == FS_RUN  && halt_req)  ? FS_HALT :
              (state_q == FS_HALT && !halt_req) ? FS_RUN  : state_q;
    fpc_d   = exc_valid      ? EXC_VECTOR :
              redirect_valid ? {redirect_target[PC_WIDTH-1:2], 2'b00} :
              push           ? fpc_q + PC_WIDTH'(4) : fpc_q;
    mis_d   = redirect_valid & ~exc_valid & |redirect_target[1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_BOOT;
      fpc_q   <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      mis_q   <= mis_d;
    end
  end
  fetch_q #(.W(PC_WIDTH + INSTR_W)) u_q (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  ({fpc_q, imem_instr}),
    .dout (head),
    .count(count)
  );
  assign imem_addr = fpc_q;
  assign out_valid = count != 2'd0;
  assign out_pc    = head[PC_WIDTH+INSTR_W-1:INSTR_W];
  assign out_instr = head[INSTR_W-1:0];
  assign misalign  = mis_q;
  assign halted    = (state_q == FS_HALT) && (count == 2'd0);
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed + random stimulus against a queue-based fetch model.
module tb_ifetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0, halt_req = 1'b0, redirect_valid = 1'b0, exc_valid = 1'b0, out_ready = 1'b0;
  logic [5:0]  redirect_target = '0;
  logic [5:0]  imem_addr, out_pc;
  logic [31:0] imem_instr, out_instr;
  logic        out_valid, misalign, halted;
  int          checks = 0, errors = 0;
  logic [31:0] rom [16] = '{32'h8C010010, 32'h8C020011, 32'h0041182A, 32'h10600009,
                            32'h20050004, 32'h20060005, 32'h20070006, 32'h20080007,
                            32'h20090008, 32'h200A0009, 32'h200B000A, 32'h200C000B,
                            32'h200D000C, 32'h00222020, 32'hAC040012, 32'h08000000};
  logic [37:0] q [$];
  int          mfpc, mst;
  logic        mmis;
  logic [5:0]  saved;

  always #5 clk = ~clk;
  assign imem_instr = rom[imem_addr[5:2]];

  ifetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .exc_valid(exc_valid),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .misalign(misalign), .halted(halted)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mfpc = 0;
    mst  = 0;
    mmis = 1'b0;
  endtask

  // compare on the falling edge, then advance the model across the rising edge
  task automatic step();
    bit pop, push, fl;
    int nfpc, nst;
    logic nmis;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0][37:32]);
      chk("out_instr", out_instr, q[0][31:0]);
    end
    chk("imem_addr", imem_addr, mfpc);
    chk("halted", halted, mst == 2 && q.size() == 0);
    chk("misalign", misalign, mmis);
    pop  = q.size() != 0 && out_ready;
    fl   = redirect_valid || exc_valid;
    push = mst == 1 && (q.size() < 2 || pop) && !fl;
    nfpc = exc_valid ? 60 : redirect_valid ? (redirect_target & 6'h3C) : push ? (mfpc + 4) % 64 : mfpc;
    nmis = redirect_valid && !exc_valid && (redirect_target % 4 != 0);
    nst  = (mst == 0 && fetch_en) ? 1 : (mst == 1 && halt_req) ? 2 : (mst == 2 && !halt_req) ? 1 : mst;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({6'(mfpc), rom[mfpc/4]});
    end
    mfpc = nfpc;
    mst  = nst;
    mmis = nmis;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_pc", out_pc, 6'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", imem_addr, 6'd0);
    chk("rst_mis", misalign, 1'b0);
    chk("rst_halted", halted, 1'b0);
    rst_n = 1'b1;
    step();
    // basic streaming
    fetch_en = 1'b1; out_ready = 1'b1;
    step();
    step(); chk("t1_pc0", out_pc, 6'd0); chk("t1_i0", out_instr, 32'h8C010010);
    step(); chk("t1_pc4", out_pc, 6'd4); chk("t1_i4", out_instr, 32'h8C020011);
    step(); chk("t1_pc8", out_pc, 6'd8); chk("t1_i8", out_instr, 32'h0041182A);
    // backpressure: queue fills and the fetch PC stalls
    out_ready = 1'b0;
    step(); saved = imem_addr;
    repeat (4) begin step(); chk("t2_hold_pc", out_pc, 6'd8); chk("t2_hold_addr", imem_addr, saved); end
    out_ready = 1'b1;
    step(); chk("t2_rel_i", out_instr, 32'h10600009);
    // redirect while full
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 6'd52;
    step(); chk("t3_flush", out_valid, 1'b0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    step(); chk("t3_pc52", out_pc, 6'd52); chk("t3_i52", out_instr, 32'h00222020);
    step(); chk("t3_pc56", out_pc, 6'd56); chk("t3_i56", out_instr, 32'hAC040012);
    step(); chk("t4_pc60", out_pc, 6'd60);
    step(); chk("t4_wrap", out_pc, 6'd0); chk("t4_wrap_i", out_instr, 32'h8C010010);
    // exception beats redirect; then a misaligned redirect
    exc_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 6'd20;
    step(); chk("t5_flush", out_valid, 1'b0); chk("t5_nomis", misalign, 1'b0);
    exc_valid = 1'b0; redirect_valid = 1'b0;
    step(); chk("t5_exc", out_pc, 6'h3C);
    redirect_valid = 1'b1; redirect_target = 6'd22;
    step(); chk("t5_mis", misalign, 1'b1);
    redirect_valid = 1'b0;
    step(); chk("t5_pc20", out_pc, 6'd20); chk("t5_mis_off", misalign, 1'b0);
    // halt with a full queue, then drain
    out_ready = 1'b0;
    repeat (2) step();
    halt_req = 1'b1;
    step(); saved = imem_addr;
    out_ready = 1'b1;
    repeat (3) step();
    chk("t6_halted", halted, 1'b1);
    chk("t6_addr_frozen", imem_addr, saved);
    halt_req = 1'b0;
    // random traffic
    repeat (400) begin
      out_ready       = $urandom_range(0, 3) != 0;
      halt_req        = $urandom_range(0, 15) == 0 ? ~halt_req : halt_req;
      redirect_valid  = $urandom_range(0, 11) == 0;
      exc_valid       = $urandom_range(0, 29) == 0;
      redirect_target = 6'($urandom);
      step();
    end
    // async reset mid-stream
    halt_req = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0; out_ready = 1'b0;
    repeat (4) step();
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_addr", imem_addr, 6'd0);
    chk("arst_pc", out_pc, 6'd0);
    chk("arst_halted", halted, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
